programmable_clock_divider: RTL and testbench
=============================================

Name: programmable_clock_divider

Overview:
- Runtime-programmable, posedge-only clock divider; successor to the fixed 2^NUM_STAGES ripple divider.
- Divides clk by any integer N in [2, 2^WIDTH-1] using a single counter in the clk domain; no ripple stages.
- Ratio changes through a valid/ready handshake and take effect only on period boundaries, so clk_div is glitch-free.
- Clean start/stop via enable; a one-cycle tick output lets synchronous logic use the divided rate without a second clock domain.

Parameters:
- WIDTH, 8, bit width of ratio and counter.
- RESET_RATIO, 128, divide ratio loaded at reset; default equals the legacy 7-stage divider. Must lie in [2, 2^WIDTH-1].

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-low reset; sampled on the posedge of clk.
- en  input  1  run request; 1 = run, 0 = stop at the end of the current period.
- cfg_valid  input  1  new ratio offered.
- cfg_ratio  input  WIDTH  requested divide ratio N.
- cfg_ready  output  1  ratio accepted when cfg_valid && cfg_ready at posedge.
- clk_div  output  1  registered divided clock.
- tick  output  1  one-cycle pulse on each clk_div rising edge.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst==0 at a posedge), all registered:
  - state=IDLE, cnt=0, ratio=RESET_RATIO, pending=0.
  - clk_div=0, tick=0.
  - cfg_ready is forced to 0 combinationally while rst==0.
  - Reset mid-period aborts immediately; no period completion.
- Derived value: H = floor(ratio/2). clk_div is high for H cycles and low for ratio-H cycles; period = ratio clk cycles.
- Clamp: cfg_ratio values 0 and 1 are stored as 2.
- States:
  - IDLE: clk_div=0, tick=0.
    - If pending, load ratio<=pending value and clear pending on that edge.
    - If en==1, go to RUN on the same edge: cnt<=0, clk_div<=1, tick<=1.
    - Pending and en on the same edge: the new ratio governs the first period.
  - RUN: each posedge, cnt_next = (cnt==ratio-1) ? 0 : cnt+1.
    - cnt<=cnt_next, clk_div<=(cnt_next<H), tick<=(cnt_next==0).
    - If en==0 sampled, go to DRAIN with no output disturbance.
  - DRAIN: counts exactly as RUN.
    - If en==1 again, return to RUN; the period is not interrupted.
    - On the wrap edge (cnt==ratio-1) with en==0: go to IDLE, cnt<=0, clk_div<=0, tick<=0. clk_div is already low in the final cycle, so there is no runt pulse.
- Ratio handshake:
  - cfg_ready = rst && !pending.
  - On acceptance, pending<=1 and the pending value <= clamped cfg_ratio.
  - In RUN/DRAIN, pending is applied on a wrap edge: ratio<=pending value, pending<=0, and the new H governs the new period starting at cnt=0.
  - Acceptance on the same edge as a wrap applies at the following wrap, never mid-period.
  - A second cfg_valid while pending stalls (cfg_ready=0); there is no overwrite.
- Latency:
  - First clk_div rise appears 1 cycle after en is sampled high in IDLE.
  - tick is coincident with the clk_div 0->1 register update.
- Reconfiguration to the same ratio is legal and invisible on the output.
- No combinational path from inputs to clk_div or tick.

Decomposition:
- Package clock_divider_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - MIN_RATIO=2;
  - function clamp_ratio(WIDTH).
- Sub-module divider_counter_core: holds cnt, ratio and H, and generates wrap, clk_div and tick from the inputs load_ratio, new_ratio and run.
- Top level holds the FSM and the pending/handshake register.

Test Plan:
- Reset default: rst=0 for 3 cycles, then en=1 → clk_div period 128 cycles, high 64, low 64; tick every 128 cycles; first rise 1 cycle after en.
- Odd ratio: write 5 in IDLE, en=1 → repeating 2 cycles high, 3 cycles low; tick on every rise.
- Mid-run change: ratio 4 running, write 7 in period middle → current period stays 4 cycles; next period is 7 (3 high, 4 low). A second write before the wrap sees cfg_ready=0 until the wrap.
- Clamp and boundary: write 0 → period 2 (1 high/1 low); write 255 with WIDTH=8 → 127 high, 128 low.
- Stop/restart: ratio 6, drop en at cnt=1 → output completes the period, then IDLE with clk_div=0 and busy=0. Re-raising en during DRAIN → no gap, periods continue.
- Reset mid-operation: rst=0 while clk_div=1, ratio 10, pending set → next edge clk_div=0, tick=0, busy=0, pending cleared, ratio back to 128.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the controller state encoding and the ratio clamp.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned MIN_RATIO = 2;

    // Ratios below 2 cannot produce a high and a low phase, so they are raised to 2.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < MIN_RATIO) ? 32'(MIN_RATIO) : ratio;
    endfunction

endpackage

// File: rtl/divider_counter_core.sv
// Period counter for the divider: holds cnt, ratio and half-ratio.
// Produces the registered clk_div/tick and the combinational wrap flag.
module divider_counter_core
    import clock_divider_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RESET_RATIO = 128
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic             stop,
    input  logic             load_ratio,
    input  logic [WIDTH-1:0] new_ratio,
    output logic             wrap,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_RATIO);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_ratio;
    logic [WIDTH-1:0] r_half;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_half_eff;

    assign wrap       = (r_cnt == (r_ratio - ONE));
    assign w_cnt_next = wrap ? '0 : (r_cnt + ONE);
    // A ratio is only loaded on a wrap, so the new half-ratio shapes the period starting now.
    assign w_half_eff = load_ratio ? (new_ratio >> 1) : r_half;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_ratio <= RESET_VAL;
            r_half  <= RESET_VAL >> 1;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (load_ratio) begin
                r_ratio <= new_ratio;
                r_half  <= new_ratio >> 1;
            end
            if (start) begin
                r_cnt   <= '0;
                clk_div <= 1'b1;
                tick    <= 1'b1;
            end else if (stop) begin
                r_cnt   <= '0;
                clk_div <= 1'b0;
                tick    <= 1'b0;
            end else if (run) begin
                r_cnt   <= w_cnt_next;
                clk_div <= (w_cnt_next < w_half_eff);
                tick    <= (w_cnt_next == '0);
            end else begin
                clk_div <= 1'b0;
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable single-clock divider: run/drain/idle controller plus
// a one-deep ratio holding register fed by a valid/ready handshake.
module programmable_clock_divider
    import clock_divider_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RESET_RATIO = 128
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_ratio,
    output logic             cfg_ready,
    output logic             clk_div,
    output logic             tick,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_pending;
    logic [WIDTH-1:0] r_pend_ratio;
    logic [WIDTH-1:0] w_clamped;
    logic             w_accept;
    logic             w_wrap;
    logic             w_start;
    logic             w_run;
    logic             w_stop;
    logic             w_load;

    assign cfg_ready = rst && !r_pending;
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_clamped = WIDTH'(clamp_ratio(32'(cfg_ratio)));
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_run        = 1'b0;
        w_stop       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = r_pending;
                if (en) begin
                    w_start      = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_run  = 1'b1;
                w_load = r_pending && w_wrap;
                if (!en) w_state_next = DRAIN;
            end
            DRAIN: begin
                w_load = r_pending && w_wrap;
                if (en) begin
                    w_run        = 1'b1;
                    w_state_next = RUN;
                end else if (w_wrap) begin
                    // Last cycle of a period is always low, so stopping here leaves no runt.
                    w_stop       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_run = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_pending    <= 1'b0;
            r_pend_ratio <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_pending    <= 1'b1;
                r_pend_ratio <= w_clamped;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    divider_counter_core #(
        .WIDTH       (WIDTH),
        .RESET_RATIO (RESET_RATIO)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .run        (w_run),
        .stop       (w_stop),
        .load_ratio (w_load),
        .new_ratio  (r_pend_ratio),
        .wrap       (w_wrap),
        .clk_div    (clk_div),
        .tick       (tick)
    );

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Bench for programmable_clock_divider: directed scenarios plus random traffic,
// compared each cycle against a period-queue model of the divider.
module tb_programmable_clock_divider;

    localparam int WIDTH       = 8;
    localparam int RESET_RATIO = 128;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [WIDTH-1:0] cfg_ratio = '0;
    logic             cfg_ready;
    logic             clk_div;
    logic             tick;
    logic             busy;

    int checks = 0;
    int failures = 0;

    // Model: a period is a queue of {clk_div, tick} samples built from the ratio.
    bit       m_active, m_drain, m_pend, m_div, m_tick;
    int       m_ratio = RESET_RATIO;
    int       m_pval;
    bit [1:0] m_q[$];

    always #5 clk = ~clk;

    programmable_clock_divider #(
        .WIDTH       (WIDTH),
        .RESET_RATIO (RESET_RATIO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .clk_div   (clk_div),
        .tick      (tick),
        .busy      (busy)
    );

    function automatic int clamp(int r);
        return (r < 2) ? 2 : r;
    endfunction

    function automatic void new_period();
        int h;
        h = m_ratio / 2;
        m_q.delete();
        for (int i = 0; i < m_ratio; i++) m_q.push_back({bit'(i < h), bit'(i == 0)});
    endfunction

    function automatic void model_step(bit r, bit e, bit v, int cr);
        bit       acc;
        bit [1:0] s;
        if (!r) begin
            m_active = 0; m_drain = 0; m_pend = 0; m_ratio = RESET_RATIO;
            m_q.delete(); m_div = 0; m_tick = 0;
            return;
        end
        acc = v && !m_pend;
        if (!m_active) begin
            if (m_pend) begin m_ratio = m_pval; m_pend = 0; end
            if (e) begin m_active = 1; new_period(); end
        end else if (m_q.size() == 0) begin
            if (m_pend) begin m_ratio = m_pval; m_pend = 0; end
            if (m_drain && !e) m_active = 0;
            else new_period();
        end
        if (m_active) begin
            s = m_q.pop_front();
            m_div = s[1]; m_tick = s[0]; m_drain = !e;
        end else begin
            m_div = 0; m_tick = 0; m_drain = 0;
        end
        if (acc) begin m_pend = 1; m_pval = clamp(cr); end
    endfunction

    function automatic logic [3:0] obs();
        return {clk_div, tick, busy, cfg_ready};
    endfunction

    function automatic logic [3:0] expv();
        return {m_div, m_tick, m_active, rst && !m_pend};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step(rst, en, cfg_valid, int'(cfg_ratio));
        #1;
    endtask

    task automatic test_reset();
        rst = 0; en = 0; cfg_valid = 0;
        repeat (3) begin
            cyc();
            checks++;
            if (obs() !== 4'b0000) begin
                failures++;
                $display("FAIL reset {div,tick,busy,ready} got=%b want=0000", obs());
            end
        end
        rst = 1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", cfg_ready);
        end
    endtask

    task automatic test_default();
        en = 1;
        cyc();
        checks++;
        if (clk_div !== 1'b1 || tick !== 1'b1) begin
            failures++;
            $display("FAIL first_rise div=%b tick=%b want 1 1", clk_div, tick);
        end
        repeat (300) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL default t=%0t got=%b want=%b", $time, obs(), expv());
            end
        end
    endtask

    task automatic test_odd();
        rst = 0; en = 0; cyc(); rst = 1;
        cfg_valid = 1; cfg_ratio = 8'd5;
        cyc();
        cfg_valid = 0; en = 1;
        repeat (30) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL odd t=%0t got=%b want=%b", $time, obs(), expv());
            end
        end
    endtask

    task automatic test_midrun();
        rst = 0; en = 0; cyc(); rst = 1;
        cfg_valid = 1; cfg_ratio = 8'd4;
        cyc();
        cfg_valid = 0; en = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 9) begin cfg_valid = 1; cfg_ratio = 8'd7; end
            if (i == 10) cfg_ratio = 8'd9;
            if (i == 18) cfg_valid = 0;
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL midrun i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_clamp();
        int  hi, len;
        bit  seen, got;
        rst = 0; en = 0; cyc(); rst = 1;
        cfg_valid = 1; cfg_ratio = 8'd0;
        cyc();
        cfg_valid = 0; en = 1;
        repeat (12) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL clamp0 t=%0t got=%b want=%b", $time, obs(), expv());
            end
        end
        cfg_valid = 1; cfg_ratio = 8'd255;
        cyc();
        cfg_valid = 0;
        hi = 0; len = 0; seen = 0; got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL clamp255 i=%0d got=%b want=%b", i, obs(), expv());
            end
            if (tick === 1'b1 && m_ratio == 255) begin
                if (seen) got = 1; else seen = 1;
            end
            if (seen && !got) begin
                len++;
                if (clk_div === 1'b1) hi++;
            end
        end
        checks++;
        if (!got || len != 255 || hi != 127) begin
            failures++;
            $display("FAIL period255 len=%0d high=%0d want 255 127", len, hi);
        end
    endtask

    task automatic test_stop_restart();
        bit found;
        rst = 0; en = 0; cyc(); rst = 1;
        cfg_valid = 1; cfg_ratio = 8'd6;
        cyc();
        cfg_valid = 0; en = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (tick === 1'b1 && i > 0) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL stop_tick_timeout got=0 want=1");
        end
        cyc();
        en = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL stop i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
        checks++;
        if (busy !== 1'b0 || clk_div !== 1'b0) begin
            failures++;
            $display("FAIL stopped busy=%b div=%b want 0 0", busy, clk_div);
        end
        en = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 8) en = 0;
            if (i == 10) en = 1;
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL restart i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 0; en = 0; cyc(); rst = 1;
        cfg_valid = 1; cfg_ratio = 8'd10;
        cyc();
        cfg_valid = 0; en = 1;
        repeat (12) cyc();
        cfg_valid = 1; cfg_ratio = 8'd3;
        cyc();
        cfg_valid = 0;
        checks++;
        if (clk_div !== 1'b1 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL premid div=%b ready=%b want 1 0", clk_div, cfg_ready);
        end
        rst = 0;
        cyc();
        checks++;
        if (obs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0000", obs());
        end
        rst = 1;
        for (int i = 0; i < 140; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL after_reset i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom % 300) != 0;
            en        = ($urandom % 8) != 0;
            cfg_valid = ($urandom % 6) == 0;
            cfg_ratio = (($urandom % 4) == 0) ? WIDTH'($urandom % 256) : WIDTH'($urandom % 10);
            cyc();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
        cfg_valid = 0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_odd();
        test_midrun();
        test_clamp();
        test_stop_restart();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
